// File: rtl/tone_arb_pkg.sv
// Shared definitions for the piezo tone arbiter.
//   TONE_W / TICKS_W : widths of tone periods and effect durations
//   SRC_*            : encodings reported on active_src
//   state_e          : arbiter FSM states
package tone_arb_pkg;

    localparam int TONE_W  = 24;
    localparam int TICKS_W = 16;

    localparam logic [1:0] SRC_STREAM = 2'd0;
    localparam logic [1:0] SRC_CLICK  = 2'd1;
    localparam logic [1:0] SRC_BEEP   = 2'd2;
    localparam logic [1:0] SRC_GAP    = 2'd3;

    typedef enum logic [1:0] {
        ST_STREAM = 2'd0,
        ST_PLAY   = 2'd1,
        ST_GAP    = 2'd2
    } state_e;

endpackage

// File: rtl/tone_tick_gen.sv
// Duration prescaler: a one-cycle tick every TICK_CYCLES clocks.
//   clk, rst  : clock, asynchronous active-low reset
//   restart   : synchronous; the next cycle begins a fresh full interval
//   tick      : high for one cycle at the end of each interval
module tone_tick_gen #(
    parameter int TICK_CYCLES = 33000
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    output logic tick
);

    localparam int CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CNT_LAST);

    always_comb begin
        if (restart || tick) cnt_d = '0;
        else                 cnt_d = cnt_q + CNT_W'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else      cnt_q <= cnt_d;
    end

endmodule

// File: rtl/tone_arbiter.sv
// Arbitrates the piezo tone generator between the music stream and two
// one-shot effects (bit 0 = click, bit 1 = beep; the beep wins).
//   clk, rst                  : clock, asynchronous active-low reset
//   stream_valid, stream_tone : music stream note (tone 0 = rest)
//   fx_start                  : one-cycle start pulses per effect
//   fx_tone, fx_ticks         : per-effect tone / duration, bit 1 in the upper half
//   mute                      : silences tone_enable, timing unaffected
//   tone, tone_enable         : registered drive to tone_generator
//   active_src                : 0 stream, 1 click, 2 beep, 3 gap
//   fx_busy                   : effect playing, in its gap, or pending
//   fx_done                   : one-cycle pulse when an effect ends normally
module tone_arbiter
    import tone_arb_pkg::*;
#(
    parameter int TICK_CYCLES = 33000,
    parameter int GAP_TICKS   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stream_valid,
    input  logic [TONE_W-1:0]    stream_tone,
    input  logic [1:0]           fx_start,
    input  logic [2*TONE_W-1:0]  fx_tone,
    input  logic [2*TICKS_W-1:0] fx_ticks,
    input  logic                 mute,
    output logic [TONE_W-1:0]    tone,
    output logic                 tone_enable,
    output logic [1:0]           active_src,
    output logic                 fx_busy,
    output logic [1:0]           fx_done
);

    localparam logic [TICKS_W-1:0] GAP_LOAD = TICKS_W'(GAP_TICKS);

    state_e                       state_q, state_d;
    logic                         cur_q, cur_d;            // playing channel
    logic [TONE_W-1:0]            cur_tone_q, cur_tone_d;
    logic [TICKS_W-1:0]           cnt_q, cnt_d;            // ticks left in PLAY or GAP
    logic [1:0]                   pend_q, pend_d;
    logic [1:0][TONE_W-1:0]       lat_tone_q, lat_tone_d;
    logic [1:0][TICKS_W-1:0]      lat_ticks_q, lat_ticks_d;

    logic [TONE_W-1:0]            tone_q, tone_d;
    logic                         en_q, en_d;
    logic [1:0]                   src_q, src_d;
    logic                         busy_q, busy_d;
    logic [1:0]                   done_q, done_d;

    logic                         tick, restart;
    logic [1:0]                   vs;         // starts with a non-zero duration
    logic [1:0]                   pend_eff;   // pending bits including this cycle's starts
    logic [1:0][TONE_W-1:0]       tone_eff;
    logic [1:0][TICKS_W-1:0]      ticks_eff;
    logic                         launch, launch_ch;

    tone_tick_gen #(.TICK_CYCLES(TICK_CYCLES)) u_tick (
        .clk     (clk),
        .rst     (rst),
        .restart (restart),
        .tick    (tick)
    );

    // Next-state logic. A start is folded into pending/latched data in the
    // same cycle so it can launch immediately (one-cycle start latency).
    always_comb begin
        // NOTE: every combinational output gets a default first; a path that
        // leaves one unassigned would infer a latch.
        vs        = fx_start & {|fx_ticks[2*TICKS_W-1:TICKS_W], |fx_ticks[TICKS_W-1:0]};
        pend_eff  = pend_q | vs;
        for (int i = 0; i < 2; i++) begin
            tone_eff[i]  = vs[i] ? fx_tone[i*TONE_W +: TONE_W]    : lat_tone_q[i];
            ticks_eff[i] = vs[i] ? fx_ticks[i*TICKS_W +: TICKS_W] : lat_ticks_q[i];
        end

        state_d     = state_q;
        cur_d       = cur_q;
        cur_tone_d  = cur_tone_q;
        cnt_d       = cnt_q;
        pend_d      = pend_eff;
        lat_tone_d  = tone_eff;
        lat_ticks_d = ticks_eff;
        done_d      = 2'b00;
        restart     = 1'b0;
        launch      = 1'b0;
        launch_ch   = pend_eff[1];

        unique case (state_q)
            ST_STREAM: launch = |pend_eff;
            ST_PLAY: begin
                if (vs[1] && !cur_q) begin
                    launch = 1'b1;                  // beep preempts click, click is dropped
                end else if (vs[cur_q]) begin
                    launch    = 1'b1;               // retrigger of the playing channel
                    launch_ch = cur_q;
                end else if (tick) begin
                    if (cnt_q == TICKS_W'(1)) begin
                        done_d[cur_q] = 1'b1;
                        if (GAP_TICKS == 0) begin
                            launch  = |pend_eff;
                            state_d = ST_STREAM;
                        end else begin
                            state_d = ST_GAP;
                            cnt_d   = GAP_LOAD;
                            restart = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q - TICKS_W'(1);
                    end
                end
            end
            ST_GAP: begin
                if (tick) begin
                    if (cnt_q == TICKS_W'(1)) begin
                        launch  = |pend_eff;
                        state_d = ST_STREAM;
                    end else begin
                        cnt_d = cnt_q - TICKS_W'(1);
                    end
                end
            end
            default: state_d = ST_STREAM;
        endcase

        if (launch) begin
            state_d           = ST_PLAY;
            cur_d             = launch_ch;
            cur_tone_d        = tone_eff[launch_ch];
            cnt_d             = ticks_eff[launch_ch];
            pend_d[launch_ch] = 1'b0;
            restart           = 1'b1;
        end
    end

    // Output logic, computed from the next state so the registered outputs
    // line up with the state they describe.
    always_comb begin
        tone_d = '0;
        en_d   = 1'b0;
        src_d  = SRC_GAP;
        busy_d = (state_d != ST_STREAM) || (|pend_d);
        unique case (state_d)
            ST_STREAM: begin
                tone_d = stream_valid ? stream_tone : '0;
                en_d   = stream_valid && (|stream_tone) && !mute;
                src_d  = SRC_STREAM;
            end
            ST_PLAY: begin
                tone_d = cur_tone_d;
                en_d   = !mute;
                src_d  = cur_d ? SRC_BEEP : SRC_CLICK;
            end
            default: ;
        endcase
    end

    // State register. NOTE: the latched effect tone/ticks are reset too; they
    // are only a few flops, and it keeps simulation free of X after reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_STREAM;
            cur_q       <= 1'b0;
            cur_tone_q  <= '0;
            cnt_q       <= '0;
            pend_q      <= 2'b00;
            lat_tone_q  <= '0;
            lat_ticks_q <= '0;
            tone_q      <= '0;
            en_q        <= 1'b0;
            src_q       <= SRC_STREAM;
            busy_q      <= 1'b0;
            done_q      <= 2'b00;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            cur_tone_q  <= cur_tone_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            lat_tone_q  <= lat_tone_d;
            lat_ticks_q <= lat_ticks_d;
            tone_q      <= tone_d;
            en_q        <= en_d;
            src_q       <= src_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign tone        = tone_q;
    assign tone_enable = en_q;
    assign active_src  = src_q;
    assign fx_busy     = busy_q;
    assign fx_done     = done_q;

endmodule

// File: tb/tb_tone_arbiter.sv
// Self-checking bench for tone_arbiter with TICK_CYCLES = 4, GAP_TICKS = 2.
module tb_tone_arbiter;

    localparam int TC = 4;
    localparam int GT = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        stream_valid;
    logic [23:0] stream_tone;
    logic [1:0]  fx_start;
    logic [47:0] fx_tone;
    logic [31:0] fx_ticks;
    logic        mute;
    logic [23:0] tone;
    logic        tone_enable;
    logic [1:0]  active_src;
    logic        fx_busy;
    logic [1:0]  fx_done;

    tone_arbiter #(.TICK_CYCLES(TC), .GAP_TICKS(GT)) dut (
        .clk          (clk),
        .rst          (rst),
        .stream_valid (stream_valid),
        .stream_tone  (stream_tone),
        .fx_start     (fx_start),
        .fx_tone      (fx_tone),
        .fx_ticks     (fx_ticks),
        .mute         (mute),
        .tone         (tone),
        .tone_enable  (tone_enable),
        .active_src   (active_src),
        .fx_busy      (fx_busy),
        .fx_done      (fx_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] tone;
        logic        en;
        logic [1:0]  src;
        logic        busy;
        logic [1:0]  done;
    } obs_t;

    typedef struct {
        logic        sv;
        logic [23:0] st;
        logic        mute;
        obs_t        exp;
    } vec_t;

    obs_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    vec_t vecs[5];

    function automatic obs_t mk(logic [23:0] t, logic e, logic [1:0] s, logic b, logic [1:0] d);
        return {t, e, s, b, d};
    endfunction

    function automatic obs_t observe();
        return {tone, tone_enable, active_src, fx_busy, fx_done};
    endfunction

    task automatic check(input string name, input obs_t got, input obs_t exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got tone=%h en=%b src=%0d busy=%b done=%b, want tone=%h en=%b src=%0d busy=%b done=%b",
                      name, got.tone, got.en, got.src, got.busy, got.done,
                      exp.tone, exp.en, exp.src, exp.busy, exp.done);
    endtask

    // One clock: queue the expectation for the edge, then compare after it.
    task automatic cyc(input string name, input obs_t e);
        obs_t want;
        sb.push_back(e);
        @(posedge clk);
        #1;
        fx_start = 2'b00;
        want = sb.pop_front();
        check(name, observe(), want);
    endtask

    task automatic hold(input string name, input int n, input obs_t e);
        repeat (n) cyc(name, e);
    endtask

    task automatic fx(input logic [1:0] start, input logic [23:0] tb_tone, input logic [23:0] tc_tone,
                      input logic [15:0] kb, input logic [15:0] kc);
        fx_start = start;
        fx_tone  = {tb_tone, tc_tone};
        fx_ticks = {kb, kc};
    endtask

    // Gap of GT*TC cycles, first one carrying fx_done.
    task automatic gap(input string name, input logic [1:0] done, input logic busy);
        cyc(name, mk(24'h0, 1'b0, 2'd3, busy, done));
        hold(name, GT*TC - 1, mk(24'h0, 1'b0, 2'd3, busy, 2'b00));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 24'h001000, 1'b0, mk(24'h001000, 1'b1, 2'd0, 1'b0, 2'b00)};
        vecs[1] = '{1'b1, 24'h000000, 1'b0, mk(24'h000000, 1'b0, 2'd0, 1'b0, 2'b00)};
        vecs[2] = '{1'b0, 24'h000055, 1'b0, mk(24'h000000, 1'b0, 2'd0, 1'b0, 2'b00)};
        vecs[3] = '{1'b1, 24'habcdef, 1'b1, mk(24'habcdef, 1'b0, 2'd0, 1'b0, 2'b00)};
        vecs[4] = '{1'b1, 24'h000123, 1'b0, mk(24'h000123, 1'b1, 2'd0, 1'b0, 2'b00)};

        rst = 1'b0;
        stream_valid = 1'b1;
        stream_tone  = 24'h1000;
        mute = 1'b0;
        fx(2'b00, 24'h0, 24'h0, 16'd0, 16'd0);

        // Outputs held at reset values while reset is asserted.
        #12;
        check("reset_hold", observe(), mk(24'h0, 1'b0, 2'd0, 1'b0, 2'b00));
        @(negedge clk);
        rst = 1'b1;

        // Stream passthrough table.
        for (int i = 0; i < 5; i++) begin
            stream_valid = vecs[i].sv;
            stream_tone  = vecs[i].st;
            mute         = vecs[i].mute;
            cyc($sformatf("pass%0d", i), vecs[i].exp);
        end
        stream_valid = 1'b1;
        stream_tone  = 24'h1000;
        mute         = 1'b0;
        cyc("stream_1000", mk(24'h1000, 1'b1, 2'd0, 1'b0, 2'b00));

        // Single click: 3 ticks = 12 cycles, 8-cycle gap, stream back.
        fx(2'b01, 24'h0, 24'h200, 16'd0, 16'd3);
        cyc("single_start", mk(24'h200, 1'b1, 2'd1, 1'b1, 2'b00));
        hold("single_play", 3*TC - 1, mk(24'h200, 1'b1, 2'd1, 1'b1, 2'b00));
        gap("single_gap", 2'b01, 1'b1);
        cyc("single_resume", mk(24'h1000, 1'b1, 2'd0, 1'b0, 2'b00));

        // Preemption: click 5 ticks, beep 6 cycles later.
        fx(2'b01, 24'h0, 24'h200, 16'd0, 16'd5);
        cyc("pre_click", mk(24'h200, 1'b1, 2'd1, 1'b1, 2'b00));
        hold("pre_click_play", 5, mk(24'h200, 1'b1, 2'd1, 1'b1, 2'b00));
        fx(2'b10, 24'h300, 24'h0, 16'd2, 16'd0);
        cyc("pre_beep", mk(24'h300, 1'b1, 2'd2, 1'b1, 2'b00));
        hold("pre_beep_play", 2*TC - 1, mk(24'h300, 1'b1, 2'd2, 1'b1, 2'b00));
        gap("pre_gap", 2'b10, 1'b1);
        cyc("pre_resume", mk(24'h1000, 1'b1, 2'd0, 1'b0, 2'b00));

        // Simultaneous starts: beep, gap, click, gap, stream.
        fx(2'b11, 24'h300, 24'h200, 16'd2, 16'd1);
        cyc("sim_beep", mk(24'h300, 1'b1, 2'd2, 1'b1, 2'b00));
        hold("sim_beep_play", 2*TC - 1, mk(24'h300, 1'b1, 2'd2, 1'b1, 2'b00));
        gap("sim_gap1", 2'b10, 1'b1);
        cyc("sim_click", mk(24'h200, 1'b1, 2'd1, 1'b1, 2'b00));
        hold("sim_click_play", TC - 1, mk(24'h200, 1'b1, 2'd1, 1'b1, 2'b00));
        gap("sim_gap2", 2'b01, 1'b1);
        cyc("sim_resume", mk(24'h1000, 1'b1, 2'd0, 1'b0, 2'b00));

        // Zero-duration starts are ignored.
        fx(2'b11, 24'h300, 24'h200, 16'd0, 16'd0);
        cyc("zero_ticks", mk(24'h1000, 1'b1, 2'd0, 1'b0, 2'b00));

        // Retrigger restarts the full duration with the new tone.
        fx(2'b01, 24'h0, 24'h200, 16'd0, 16'd3);
        cyc("retrig_start", mk(24'h200, 1'b1, 2'd1, 1'b1, 2'b00));
        hold("retrig_play1", 5, mk(24'h200, 1'b1, 2'd1, 1'b1, 2'b00));
        fx(2'b01, 24'h0, 24'h240, 16'd0, 16'd3);
        cyc("retrig_again", mk(24'h240, 1'b1, 2'd1, 1'b1, 2'b00));
        hold("retrig_play2", 3*TC - 1, mk(24'h240, 1'b1, 2'd1, 1'b1, 2'b00));
        gap("retrig_gap", 2'b01, 1'b1);
        cyc("retrig_resume", mk(24'h1000, 1'b1, 2'd0, 1'b0, 2'b00));

        // Mute: silent effect, unchanged timing.
        mute = 1'b1;
        fx(2'b01, 24'h0, 24'h200, 16'd0, 16'd2);
        cyc("mute_start", mk(24'h200, 1'b0, 2'd1, 1'b1, 2'b00));
        hold("mute_play", 2*TC - 1, mk(24'h200, 1'b0, 2'd1, 1'b1, 2'b00));
        gap("mute_gap", 2'b01, 1'b1);
        cyc("mute_stream", mk(24'h1000, 1'b0, 2'd0, 1'b0, 2'b00));
        mute = 1'b0;
        cyc("unmute_stream", mk(24'h1000, 1'b1, 2'd0, 1'b0, 2'b00));

        // Reset mid-effect: asynchronous clear, no fx_done afterwards.
        fx(2'b10, 24'h300, 24'h0, 16'd4, 16'd0);
        cyc("rst_fx_start", mk(24'h300, 1'b1, 2'd2, 1'b1, 2'b00));
        cyc("rst_fx_play", mk(24'h300, 1'b1, 2'd2, 1'b1, 2'b00));
        #2;
        rst = 1'b0;
        #1;
        check("rst_async", observe(), mk(24'h0, 1'b0, 2'd0, 1'b0, 2'b00));
        @(negedge clk);
        check("rst_held", observe(), mk(24'h0, 1'b0, 2'd0, 1'b0, 2'b00));
        rst = 1'b1;
        cyc("rst_resume", mk(24'h1000, 1'b1, 2'd0, 1'b0, 2'b00));
        hold("rst_no_done", 2*TC, mk(24'h1000, 1'b1, 2'd0, 1'b0, 2'b00));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
